// File: rtl/life_pkg.sv
// Shared frame geometry, seeder mode encodings, seeder FSM states and the
// xorshift32 step function for the life frame-buffer tooling.
package life_pkg;

  localparam int H_ACTIVE    = 800;
  localparam int V_ACTIVE    = 600;
  localparam int H_BYTES     = H_ACTIVE / 8;
  localparam int V_LINES     = V_ACTIVE;
  localparam int FRAME_BYTES = H_BYTES * V_LINES;

  localparam logic [1:0] MODE_CLEAR  = 2'd0;
  localparam logic [1:0] MODE_FILL   = 2'd1;
  localparam logic [1:0] MODE_CHECK  = 2'd2;
  localparam logic [1:0] MODE_RANDOM = 2'd3;

  localparam logic [31:0] LIFE_SEED = 32'h2545F491;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } seeder_state_e;

  function automatic logic [31:0] xorshift32_step(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

endpackage

// File: rtl/life_xorshift32.sv
// Registered xorshift32 generator: loads SEED on reset, advances one step when
// step_en_i is high, and exposes both the current and the next state.
module life_xorshift32
  import life_pkg::*;
#(
  parameter logic [31:0] SEED = LIFE_SEED
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        step_en_i,
  output logic [31:0] state_o,
  output logic [31:0] next_o
);

  logic [31:0] state_q;
  logic [31:0] state_d;

  assign next_o  = xorshift32_step(state_q);
  assign state_o = state_q;

  // Advance only on request so the sequence position tracks accepted bytes.
  always_comb begin
    state_d = state_q;
    if (step_en_i) begin
      state_d = next_o;
    end else begin
      state_d = state_q;
    end
  end

  // State register; reset is the only reload path.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/life_seeder.sv
// Frame-buffer seeder: streams one pattern byte per accepted write request.
// Build option: LIFE_SEEDER_BORDER_CLEAR_EN forces the frame's edge cells dead.
module life_seeder
  import life_pkg::*;
#(
  parameter int          ADDR_W  = 19,
  parameter int          H_BYTES = life_pkg::H_BYTES,
  parameter int          V_LINES = life_pkg::V_LINES,
  parameter logic [31:0] SEED    = LIFE_SEED
) (
  input  logic              clk_pixel,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [2:0]        density,
  output logic              busy,
  output logic              done,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic              wr_ack
);

  localparam int COL_W = (H_BYTES > 1) ? $clog2(H_BYTES) : 1;
  localparam int ROW_W = (V_LINES > 1) ? $clog2(V_LINES) : 1;

  localparam logic [COL_W-1:0]  COL_ONE   = COL_W'(1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(H_BYTES - 1);
  localparam logic [ROW_W-1:0]  ROW_ONE   = ROW_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_BYTES * V_LINES - 1);
`ifdef LIFE_SEEDER_BORDER_CLEAR_EN
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(V_LINES - 1);
`endif

  seeder_state_e     state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d, col_n_s;
  logic [ROW_W-1:0]  row_q, row_d, row_n_s;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              req_q, req_d;
  logic [1:0]        mode_q, mode_d;
  logic [2:0]        dens_q, dens_d;
  logic              lfsr_step_s;
  logic [31:0]       lfsr_state_s, lfsr_next_s;
  logic [7:0]        first_byte_s, step_byte_s;

  function automatic logic [7:0] pattern_byte(input logic [1:0] m, input logic [2:0] d,
                                              input logic odd_row, input logic [31:0] x);
    logic [7:0] b;
    b = 8'h00;
    case (m)
      MODE_CLEAR:  b = 8'h00;
      MODE_FILL:   b = 8'hFF;
      MODE_CHECK:  b = odd_row ? 8'h55 : 8'hAA;
      MODE_RANDOM: for (int i = 0; i < 8; i++) b[i] = (x[3*i +: 3] < d);
      default:     b = 8'h00;
    endcase
    return b;
  endfunction

`ifdef LIFE_SEEDER_BORDER_CLEAR_EN
  function automatic logic [7:0] border_clear(input logic [7:0] b, input logic [ROW_W-1:0] r,
                                              input logic [COL_W-1:0] c);
    logic [7:0] o;
    o = b;
    if ((r == {ROW_W{1'b0}}) || (r == ROW_LAST)) begin
      o = 8'h00;
    end else begin
      if (c == {COL_W{1'b0}}) o = o & 8'h7F;
      else                    o = o;
      if (c == COL_LAST)      o = o & 8'hFE;
      else                    o = o;
    end
    return o;
  endfunction
`endif

  life_xorshift32 #(.SEED(SEED)) u_lfsr (
    .clk_i     (clk_pixel),
    .rst_i     (rst),
    .step_en_i (lfsr_step_s),
    .state_o   (lfsr_state_s),
    .next_o    (lfsr_next_s)
  );

  // Raster position following the byte currently on the bus.
  always_comb begin
    col_n_s = col_q + COL_ONE;
    row_n_s = row_q;
    if (col_q == COL_LAST) begin
      col_n_s = {COL_W{1'b0}};
      row_n_s = row_q + ROW_ONE;
    end else begin
      row_n_s = row_q;
    end
  end

  // The following byte uses the LFSR value it will hold after this ack.
  always_comb begin
`ifdef LIFE_SEEDER_BORDER_CLEAR_EN
    first_byte_s = border_clear(pattern_byte(mode, density, 1'b0, lfsr_state_s),
                                {ROW_W{1'b0}}, {COL_W{1'b0}});
    step_byte_s  = border_clear(pattern_byte(mode_q, dens_q, row_n_s[0], lfsr_next_s),
                                row_n_s, col_n_s);
`else
    first_byte_s = pattern_byte(mode, density, 1'b0, lfsr_state_s);
    step_byte_s  = pattern_byte(mode_q, dens_q, row_n_s[0], lfsr_next_s);
`endif
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    addr_d      = addr_q;
    data_d      = data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    req_d       = req_q;
    mode_d      = mode_q;
    dens_d      = dens_q;
    lfsr_step_s = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        req_d  = 1'b0;
        if (start && !abort) begin
          mode_d  = mode;
          dens_d  = density;
          col_d   = {COL_W{1'b0}};
          row_d   = {ROW_W{1'b0}};
          addr_d  = {ADDR_W{1'b0}};
          data_d  = first_byte_s;
          busy_d  = 1'b1;
          req_d   = 1'b1;
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        lfsr_step_s = wr_ack;
        if (abort) begin
          busy_d  = 1'b0;
          req_d   = 1'b0;
          state_d = IDLE;
        end else if (wr_ack && (addr_q == ADDR_LAST)) begin
          busy_d  = 1'b0;
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (wr_ack) begin
          col_d  = col_n_s;
          row_d  = row_n_s;
          addr_d = addr_q + ADDR_ONE;
          data_d = step_byte_s;
        end else begin
          state_d = REQ;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        req_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops the request asynchronously.
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= {COL_W{1'b0}};
      row_q   <= {ROW_W{1'b0}};
      addr_q  <= {ADDR_W{1'b0}};
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      mode_q  <= MODE_CLEAR;
      dens_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      req_q   <= req_d;
      mode_q  <= mode_d;
      dens_q  <= dens_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign wr_req  = req_q;
  assign wr_addr = addr_q;
  assign wr_data = data_q;

endmodule

// File: tb/tb_life_seeder.sv
// Directed/randomised bench for life_seeder on a reduced 100x6-byte frame,
// checked against a frame-level reference model of the pattern rules.
module tb_life_seeder;

  localparam int          H     = 100;
  localparam int          V     = 6;
  localparam int          FRAME = H * V;
  localparam int          LAST  = FRAME - 1;
  localparam int unsigned SEEDV = 32'h2545F491;
  localparam int          BUDGET = 8 * FRAME + 20;

  logic        clk_pixel = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [2:0]  density = 3'd0;
  logic        busy, done, wr_req, wr_ack;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned m_lfsr = SEEDV;
  int          nacks;
  int          ones;
  logic [7:0]  frame_mem [FRAME];
  logic [7:0]  rec_q [$];
  logic [7:0]  ref_q [$];

  life_seeder #(.ADDR_W(19), .H_BYTES(H), .V_LINES(V), .SEED(32'h2545F491)) dut (
    .clk_pixel (clk_pixel),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .mode      (mode),
    .density   (density),
    .busy      (busy),
    .done      (done),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned xs32(input int unsigned x);
    int unsigned t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  // Byte the frame should hold at (row, col) given the generator value x.
  function automatic logic [7:0] model_byte(input int m, input int d, input int row,
                                            input int col, input int unsigned x);
    logic [7:0] b;
    b = 8'h00;
    if (m == 1) b = 8'hFF;
    else if (m == 2) b = (row % 2 == 1) ? 8'h55 : 8'hAA;
    else if (m == 3) begin
      for (int i = 0; i < 8; i++) b[i] = (((x >> (3 * i)) & 32'd7) < d);
    end
`ifdef LIFE_SEEDER_BORDER_CLEAR_EN
    if (row == 0 || row == V - 1) b = 8'h00;
    else begin
      if (col == 0) b = b & 8'h7F;
      if (col == H - 1) b = b & 8'hFE;
    end
`endif
    return b;
  endfunction

  task automatic reset_dut();
    rst = 1'b1;
    wr_ack = 1'b0;
    repeat (2) @(posedge clk_pixel);
    #1;
    rst = 1'b0;
    m_lfsr = SEEDV;
  endtask

  // One seed pass. ack_kind: 0 always, 1 every third cycle, 2 random.
  task automatic run_pass(input int m, input int d, input int ack_kind,
                          input int abort_at, input int rst_at);
    int row, col, addr, cyc;
    logic [7:0] ed;
    bit ack_now, ab_now, fin;
    nacks = 0; ones = 0; rec_q.delete();
    mode = 2'(m); density = 3'(d); start = 1'b1;
    @(posedge clk_pixel); #1;
    start = 1'b0;
    row = 0; col = 0; addr = 0; cyc = 0; fin = 1'b0;
    ed = model_byte(m, d, 0, 0, m_lfsr);
    while (!fin && cyc < BUDGET) begin
      if (rst_at >= 0 && nacks == rst_at) begin
        #2 rst = 1'b1;
        #1;
        check("rst_req_async", {31'd0, wr_req}, 32'd0);
        check("rst_busy_async", {31'd0, busy}, 32'd0);
        check("rst_addr_async", {13'd0, wr_addr}, 32'd0);
        @(posedge clk_pixel); #1;
        rst = 1'b0;
        m_lfsr = SEEDV;
        fin = 1'b1;
        break;
      end
      check("busy_hi", {31'd0, busy}, 32'd1);
      check("req_hi", {31'd0, wr_req}, 32'd1);
      check("done_lo", {31'd0, done}, 32'd0);
      check("addr", {13'd0, wr_addr}, addr);
      check("data", {24'd0, wr_data}, {24'd0, ed});
      case (ack_kind)
        0:       ack_now = 1'b1;
        1:       ack_now = (cyc % 3 == 2);
        default: ack_now = 1'($urandom_range(0, 1));
      endcase
      ab_now  = (abort_at >= 0 && nacks == abort_at);
      wr_ack  = ack_now;
      abort   = ab_now;
      mode    = 2'($urandom);
      density = 3'($urandom);
      start   = (cyc == 5);
      @(posedge clk_pixel); #1;
      wr_ack = 1'b0; abort = 1'b0; start = 1'b0;
      cyc++;
      if (ack_now) begin
        ones += $countones(ed);
        rec_q.push_back(ed);
        frame_mem[addr] = ed;
        nacks++;
        m_lfsr = xs32(m_lfsr);
      end
      if (ab_now) begin
        check("abort_req", {31'd0, wr_req}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(posedge clk_pixel); #1;
        check("abort_done2", {31'd0, done}, 32'd0);
        fin = 1'b1;
      end else if (ack_now && addr == LAST) begin
        check("done_pulse", {31'd0, done}, 32'd1);
        check("done_busy", {31'd0, busy}, 32'd0);
        check("done_req", {31'd0, wr_req}, 32'd0);
        @(posedge clk_pixel); #1;
        check("done_once", {31'd0, done}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        fin = 1'b1;
      end else if (ack_now) begin
        addr++;
        col++;
        if (col == H) begin
          col = 0;
          row++;
        end
        ed = model_byte(m, d, row, col, m_lfsr);
      end
    end
    check("pass_ended", {31'd0, fin}, 32'd1);
  endtask

  initial begin
    int mism;
    int total;
    wr_ack = 1'b0;
    reset_dut();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_req", {31'd0, wr_req}, 32'd0);
    check("rst_addr", {13'd0, wr_addr}, 32'd0);
    check("rst_data", {24'd0, wr_data}, 32'd0);

    // Random soup at density 4 from a fresh SEED.
    run_pass(3, 4, 0, -1, -1);
    ref_q = rec_q;
    check("rand_first", {24'd0, ref_q[0]}, {24'd0, model_byte(3, 4, 0, 0, SEEDV)});
    total = nacks * 8;
    check("rand_ones_frac", {31'd0, (ones * 100 >= 45 * total) && (ones * 100 <= 55 * total)}, 32'd1);

    run_pass(0, 0, 0, -1, -1);
    check("clear_count", nacks, FRAME);
    run_pass(1, 0, 1, -1, -1);
    check("fill_stall_count", nacks, FRAME);

    run_pass(2, 0, 2, -1, -1);
    check("check_count", nacks, FRAME);
`ifdef LIFE_SEEDER_BORDER_CLEAR_EN
    check("check_99", {24'd0, frame_mem[99]}, 32'h00);
    check("check_100", {24'd0, frame_mem[100]}, 32'h55);
    check("check_199", {24'd0, frame_mem[199]}, 32'h54);
    check("check_last", {24'd0, frame_mem[LAST]}, 32'h00);
`else
    check("check_99", {24'd0, frame_mem[99]}, 32'hAA);
    check("check_100", {24'd0, frame_mem[100]}, 32'h55);
    check("check_199", {24'd0, frame_mem[199]}, 32'h55);
    check("check_last", {24'd0, frame_mem[LAST]}, 32'h55);
`endif

    run_pass(3, 0, 2, -1, -1);
    check("dens0_ones", ones, 0);

    // start together with abort in IDLE is ignored.
    start = 1'b1; abort = 1'b1; mode = 2'd1;
    @(posedge clk_pixel); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", {31'd0, busy}, 32'd0);
    check("start_abort_req", {31'd0, wr_req}, 32'd0);
    @(posedge clk_pixel); #1;
    check("start_abort_req2", {31'd0, wr_req}, 32'd0);

    run_pass(1, 0, 0, 100, -1);
    check("abort_acks", nacks, 101);
    run_pass(0, 0, 0, -1, -1);
    check("restart_count", nacks, FRAME);

    // Reset mid-pass, then the soup replays from SEED.
    run_pass(3, 4, 0, -1, 300);
    check("rst_mid_acks", nacks, 300);
    run_pass(3, 4, 0, -1, -1);
    check("replay_len", rec_q.size(), ref_q.size());
    mism = 0;
    for (int i = 0; i < rec_q.size() && i < ref_q.size(); i++) begin
      if (rec_q[i] !== ref_q[i]) mism++;
    end
    check("replay_seq", mism, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
